// File: rtl/cpu6_lsu_pkg.sv
// cpu6 load/store unit: shared widths, encodings, state and request types.
// Optional bus timeout is enabled with `define CPU6_LSU_TIMEOUT_EN.
`ifndef CPU6_LSU_DEFINES
`define CPU6_LSU_DEFINES
`define CPU6_LSWIDTH_SIZE 2
`define CPU6_LSWIDTH_B 2'b00
`define CPU6_LSWIDTH_H 2'b01
`define CPU6_LSWIDTH_W 2'b10
`define CPU6_LSU_ST_SIZE 2
`define CPU6_LSU_ST_IDLE 2'd0
`define CPU6_LSU_ST_WAIT 2'd1
`define CPU6_LSU_ST_DONE 2'd2
`define CPU6_LSU_BE_SIZE 4
`endif

package cpu6_lsu_pkg;

  localparam int LSW_W = `CPU6_LSWIDTH_SIZE;
  localparam int BE_W = `CPU6_LSU_BE_SIZE;

  localparam logic [LSW_W-1:0] LSW_BYTE = `CPU6_LSWIDTH_B;
  localparam logic [LSW_W-1:0] LSW_HALF = `CPU6_LSWIDTH_H;
  localparam logic [LSW_W-1:0] LSW_WORD = `CPU6_LSWIDTH_W;

  typedef enum logic [`CPU6_LSU_ST_SIZE-1:0] {
    LSU_IDLE = `CPU6_LSU_ST_IDLE,
    LSU_WAIT = `CPU6_LSU_ST_WAIT,
    LSU_DONE = `CPU6_LSU_ST_DONE
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [LSW_W-1:0] width;
    logic signext;
    logic we;
    logic [BE_W-1:0] be;
    logic [31:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/cpu6_lsu_align.sv
// cpu6 LSU lane logic: store replication/byte enables, misalign check,
// and load lane select with sign/zero extension. Purely combinational.
module cpu6_lsu_align
  import cpu6_lsu_pkg::*;
(
  input  logic [LSW_W-1:0] st_width,
  input  logic [1:0]       st_off,
  input  logic [31:0]      st_data,
  output logic [BE_W-1:0]  st_be,
  output logic [31:0]      st_wdata,
  output logic             misalign,
  input  logic [LSW_W-1:0] ld_width,
  input  logic [1:0]       ld_off,
  input  logic             ld_signext,
  input  logic [31:0]      ld_raw,
  output logic [31:0]      ld_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    st_be = '0;
    st_wdata = '0;
    misalign = 1'b0;
    unique case (1'b1)
      st_width == LSW_BYTE: begin
        st_be = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      st_width == LSW_HALF: begin
        st_be = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
        misalign = st_off[0];
      end
      st_width == LSW_WORD: begin
        st_be = 4'b1111;
        st_wdata = st_data;
        misalign = |st_off;
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    unique case (ld_off)
      2'd0: lane_b = ld_raw[7:0];
      2'd1: lane_b = ld_raw[15:8];
      2'd2: lane_b = ld_raw[23:16];
      default: lane_b = ld_raw[31:24];
    endcase
    lane_h = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
  end

  always_comb begin
    ld_data = ld_raw;
    unique case (1'b1)
      ld_width == LSW_BYTE:
        ld_data = {{24{ld_signext & lane_b[7]}}, lane_b};
      ld_width == LSW_HALF:
        ld_data = {{16{ld_signext & lane_h[15]}}, lane_h};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/cpu6_lsu.sv
// cpu6 load/store unit: one word-aligned req/ack bus access per request.
// Define CPU6_LSU_TIMEOUT_EN to abort WAIT with a bus error after TIMEOUT.
module cpu6_lsu
  import cpu6_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ex_valid,
  input  logic                          ex_memread,
  input  logic                          ex_memwrite,
  input  logic [`CPU6_LSWIDTH_SIZE-1:0] ex_lswidth,
  input  logic                          ex_loadsignext,
  input  logic [31:0]                   ex_addr,
  input  logic [31:0]                   ex_wdata,
  output logic                          lsu_stall,
  output logic                          lsu_done,
  output logic [31:0]                   lsu_rdata,
  output logic                          lsu_misalign,
  output logic                          lsu_buserr,
  output logic                          bus_req,
  output logic                          bus_we,
  output logic [31:0]                   bus_addr,
  output logic [BE_W-1:0]               bus_be,
  output logic [31:0]                   bus_wdata,
  input  logic                          bus_ack,
  input  logic [31:0]                   bus_rdata
);

  lsu_state_e state, next;
  lsu_req_t   req;

  logic            access;
  logic            in_wait;
  logic            in_done;
  logic            timeout;
  logic            misal_in;
  logic            misal_q;
  logic [BE_W-1:0] st_be;
  logic [31:0]     st_wdata;
  logic [31:0]     ld_data;
  logic [31:0]     rdata_q;

  assign access = ex_valid & (ex_memread | ex_memwrite);
  assign in_wait = (state == LSU_WAIT);
  assign in_done = (state == LSU_DONE);

  cpu6_lsu_align u_align (
    .st_width   (ex_lswidth),
    .st_off     (ex_addr[1:0]),
    .st_data    (ex_wdata),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .misalign   (misal_in),
    .ld_width   (req.width),
    .ld_off     (req.addr[1:0]),
    .ld_signext (req.signext),
    .ld_raw     (bus_rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= LSU_IDLE;
    else state <= next;
  end

  always_comb begin
    next = state;
    lsu_stall = 1'b0;
    unique case (state)
      LSU_IDLE: begin
        if (access) begin
          lsu_stall = 1'b1;
          next = misal_in ? LSU_DONE : LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        lsu_stall = 1'b1;
        if (bus_ack || timeout) next = LSU_DONE;
      end
      LSU_DONE: next = LSU_IDLE;
      default: next = LSU_IDLE;
    endcase
  end

  // Write wins when both memread and memwrite are set.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      req <= '0;
      misal_q <= 1'b0;
      rdata_q <= '0;
    end else if (state == LSU_IDLE && access) begin
      req <= '{addr: ex_addr, width: ex_lswidth,
               signext: ex_loadsignext, we: ex_memwrite,
               be: st_be, wdata: st_wdata};
      misal_q <= misal_in;
      rdata_q <= '0;
    end else if (in_wait && bus_ack) begin
      rdata_q <= req.we ? '0 : ld_data;
    end
  end

`ifdef CPU6_LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          buserr_q;

  // This WAIT cycle is the TIMEOUT-th one; an ack in it still wins.
  assign timeout = in_wait && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
      buserr_q <= 1'b0;
    end else if (state == LSU_IDLE) begin
      cnt <= '0;
      buserr_q <= 1'b0;
    end else if (in_wait && !bus_ack) begin
      cnt <= cnt + CW'(1);
      buserr_q <= timeout;
    end
  end

  assign lsu_buserr = in_done & buserr_q;
`else
  assign timeout = 1'b0;
  assign lsu_buserr = 1'b0;
`endif

  assign lsu_done = in_done;
  assign lsu_rdata = in_done ? rdata_q : '0;
  assign lsu_misalign = in_done & misal_q;

  assign bus_req = in_wait;
  assign bus_we = in_wait & req.we;
  assign bus_addr = in_wait ? {req.addr[31:2], 2'b00} : '0;
  assign bus_be = in_wait ? req.be : '0;
  assign bus_wdata = in_wait ? req.wdata : '0;

endmodule

// File: tb/tb_cpu6_lsu.sv
// Randomized self-checking bench for cpu6_lsu against a behavioural model.
// Timeout scenarios run only when CPU6_LSU_TIMEOUT_EN is defined.
module tb_cpu6_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_memread = 1'b0;
  logic        ex_memwrite = 1'b0;
  logic [1:0]  ex_lswidth = 2'b00;
  logic        ex_loadsignext = 1'b0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic        lsu_stall;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_misalign;
  logic        lsu_buserr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cpu6_lsu #(.TIMEOUT(TMO)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ex_valid       (ex_valid),
    .ex_memread     (ex_memread),
    .ex_memwrite    (ex_memwrite),
    .ex_lswidth     (ex_lswidth),
    .ex_loadsignext (ex_loadsignext),
    .ex_addr        (ex_addr),
    .ex_wdata       (ex_wdata),
    .lsu_stall      (lsu_stall),
    .lsu_done       (lsu_done),
    .lsu_rdata      (lsu_rdata),
    .lsu_misalign   (lsu_misalign),
    .lsu_buserr     (lsu_buserr),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_be         (bus_be),
    .bus_wdata      (bus_wdata),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".done"}, {31'd0, lsu_done}, 0);
    check({tag, ".req"}, {31'd0, bus_req}, 0);
    check({tag, ".stall"}, {31'd0, lsu_stall}, 0);
    check({tag, ".rdata"}, lsu_rdata, 0);
    check({tag, ".flags"}, {30'd0, lsu_misalign, lsu_buserr}, 0);
  endtask

  // One access; dly = WAIT cycles before the ack cycle.
  task automatic run(input logic [1:0] w, input logic [31:0] a,
                     input logic [31:0] d, input logic rd, input logic wr,
                     input logic sx, input logic [31:0] rdw,
                     input int dly);
    int sz, off, nw;
    bit mis, to, we;
    logic [31:0] m, v, exp_wd, exp_rd, t;
    logic [3:0] exp_be;
    sz = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    we = wr;
    mis = (w == 2'd3) || ((a % sz) != 0);
    t = ((32'd1 << sz) - 1) << off;
    exp_be = t[3:0];
    if (sz == 1) exp_wd = (d & 32'hFF) * 32'h01010101;
    else if (sz == 2) exp_wd = (d & 32'hFFFF) * 32'h00010001;
    else exp_wd = d;
    if (sz == 4) v = rdw;
    else begin
      m = (sz == 1) ? 32'hFF : 32'hFFFF;
      v = (rdw >> (8 * off)) & m;
      if (sx && v[8*sz-1]) v = v | ~m;
    end
    exp_rd = we ? 32'd0 : v;
`ifdef CPU6_LSU_TIMEOUT_EN
    to = dly >= TMO;
`else
    to = 1'b0;
`endif
    nw = mis ? 0 : (to ? TMO : dly + 1);

    @(negedge clk);
    ex_valid = 1'b1;
    ex_memread = rd;
    ex_memwrite = wr;
    ex_lswidth = w;
    ex_loadsignext = sx;
    ex_addr = a;
    ex_wdata = d;
    #1;
    check("accept.stall", {31'd0, lsu_stall}, 1);
    check("accept.req", {31'd0, bus_req}, 0);
    @(posedge clk);
    #1;
    ex_valid = $urandom_range(0, 1) == 1;
    ex_addr = $urandom;
    ex_wdata = $urandom;
    for (int k = 0; k < nw; k++) begin
      @(negedge clk);
      check("wait.req", {31'd0, bus_req}, 1);
      check("wait.stall", {31'd0, lsu_stall}, 1);
      check("wait.done", {31'd0, lsu_done}, 0);
      check("wait.we", {31'd0, bus_we}, {31'd0, we});
      check("wait.addr", bus_addr, a & ~32'd3);
      check("wait.be", {28'd0, bus_be}, {28'd0, exp_be});
      if (we) check("wait.wdata", bus_wdata, exp_wd);
      bus_ack = !to && (k == nw - 1);
      bus_rdata = bus_ack ? rdw : $urandom;
    end
    @(negedge clk);
    bus_ack = 1'b0;
    check("done.done", {31'd0, lsu_done}, 1);
    check("done.stall", {31'd0, lsu_stall}, 0);
    check("done.req", {31'd0, bus_req}, 0);
    check("done.mis", {31'd0, lsu_misalign}, {31'd0, mis});
    check("done.berr", {31'd0, lsu_buserr}, {31'd0, to});
    check("done.rdata", lsu_rdata, (mis || to) ? 32'd0 : exp_rd);
    ex_valid = 1'b0;
    @(negedge clk);
    check_idle("after");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset.be", {28'd0, bus_be}, 0);
    check("reset.addr", bus_addr, 0);
    resetn = 1'b1;
    @(negedge clk);
    check_idle("postreset");

    run(2'd2, 32'h100, 32'hDEADBEEF, 0, 1, 0, 32'h0, 0);
    run(2'd0, 32'h203, 32'h0, 1, 0, 1, 32'h80123456, 0);
    run(2'd0, 32'h203, 32'h0, 1, 0, 0, 32'h80123456, 1);
    run(2'd1, 32'h102, 32'h00001234, 0, 1, 0, 32'h0, 3);
    run(2'd1, 32'h102, 32'h0, 1, 0, 1, 32'h8001F00F, 0);
    run(2'd2, 32'h101, 32'h0, 1, 0, 1, 32'h0, 0);
    run(2'd1, 32'h101, 32'h0, 1, 0, 1, 32'h0, 0);
    run(2'd3, 32'h100, 32'h0, 1, 0, 0, 32'h0, 0);
    run(2'd0, 32'h001, 32'hA5, 1, 1, 1, 32'hFFFFFFFF, 2);
`ifdef CPU6_LSU_TIMEOUT_EN
    run(2'd2, 32'h300, 32'h0, 1, 0, 0, 32'h12345678, TMO + 2);
    run(2'd2, 32'h300, 32'h0, 1, 0, 0, 32'h12345678, TMO - 1);
`endif

    // Reset while in WAIT, then a stray ack must be ignored.
    @(negedge clk);
    ex_valid = 1'b1;
    ex_memread = 1'b1;
    ex_memwrite = 1'b0;
    ex_lswidth = 2'd2;
    ex_addr = 32'h400;
    @(negedge clk);
    ex_valid = 1'b0;
    check("rst.wait.req", {31'd0, bus_req}, 1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_idle("rst.next");
    bus_ack = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus_ack = 1'b0;
    check_idle("rst.ack1");
    @(negedge clk);
    check_idle("rst.ack2");

    for (int i = 0; i < 300; i++) begin
      logic [1:0] w;
      logic [31:0] a;
      int op, mx;
      w = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (w == 2'd1) a[0] = 1'b0;
        if (w == 2'd2) a[1:0] = 2'b00;
      end
      op = $urandom_range(0, 2);
`ifdef CPU6_LSU_TIMEOUT_EN
      mx = TMO + 1;
`else
      mx = 3;
`endif
      run(w, a, $urandom, op != 1, op != 0, 1'($urandom_range(0, 1)),
          $urandom, $urandom_range(0, mx));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
